// File: rtl/sddr_device_model_if.sv
// Device-side DDR3 pin bundle: command/address/write-data from the controller,
// two-lane read data (lane 0 = even beat, lane 1 = odd beat) back from the device.
interface sddr_device_model_if #(
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 13,
  parameter int DATA_BITS = 16
) ();
  localparam int ADDR_BITS = ROW_BITS + $clog2(DATA_BITS / 8);

  logic                          cke_i;
  logic                          cs_n_i;
  logic                          ras_n_i;
  logic                          cas_n_i;
  logic                          we_n_i;
  logic [BANK_BITS-1:0]          ba_i;
  logic [ADDR_BITS-1:0]          addr_i;
  logic                          odt_i;
  logic [1:0][DATA_BITS-1:0]     dq_i;
  logic [1:0][DATA_BITS-1:0]     dq_o;
  logic                          dq_oe_o;

  modport master (
    output cke_i, cs_n_i, ras_n_i, cas_n_i, we_n_i, ba_i, addr_i, odt_i, dq_i,
    input  dq_o, dq_oe_o
  );

  modport slave (
    input  cke_i, cs_n_i, ras_n_i, cas_n_i, we_n_i, ba_i, addr_i, odt_i, dq_i,
    output dq_o, dq_oe_o
  );
endinterface

// File: rtl/sddr_device_model.sv
// Cycle-based DDR3 device responder: bank/row tracking, burst backing RAM, protocol checks.
// Define SDDR_MODEL_TIMING_CHECK_EN to add tRCD/tRP/tRFC counters and error codes 5/6.
module sddr_device_model #(
  parameter int BANK_BITS         = 3,
  parameter int ROW_BITS          = 13,
  parameter int COL_BITS          = 10,
  parameter int DATA_BITS         = 16,
  parameter int BURST_LENGTH      = 8,
  parameter int CAS_READ_LATENCY  = 5,
  parameter int CAS_WRITE_LATENCY = 5,
  parameter int STORE_BITS        = 8,
  parameter int tRCD              = 3,
  parameter int tRP               = 3,
  parameter int tRFC              = 20
) (
  input  logic                    ddr_clock_i,
  input  logic                    ddr_reset_i,
  sddr_device_model_if.slave      ddr3_io,
  output logic [2**BANK_BITS-1:0] bank_open_o,
  output logic [15:0]             refresh_count_o,
  output logic                    err_o,
  output logic [3:0]              err_code_o
);
  localparam int NB       = 2 ** BANK_BITS;
  localparam int BL_LOG   = $clog2(BURST_LENGTH);
  localparam int PAIRS    = BURST_LENGTH / 2;
  localparam int PIDX_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int KEY_BITS = BANK_BITS + ROW_BITS + COL_BITS - BL_LOG;
  localparam logic [7:0]  RD_LAT  = 8'(CAS_READ_LATENCY);
  localparam logic [7:0]  WR_LAT  = 8'(CAS_WRITE_LATENCY);
  localparam logic [7:0]  P_LAST  = 8'(PAIRS - 1);
  localparam logic [7:0]  TRCD_LD = 8'((tRCD > 0) ? tRCD - 1 : 0);
  localparam logic [7:0]  TRP_LD  = 8'((tRP > 0) ? tRP - 1 : 0);
  localparam logic [15:0] TRFC_LD = 16'((tRFC > 0) ? tRFC - 1 : 0);

  localparam logic [3:0] C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001;
  localparam logic [3:0] E_NONE = 4'd0, E_ACT_OPEN = 4'd1, E_CLOSED = 4'd2;
  localparam logic [3:0] E_BUSY = 4'd3, E_REF_OPEN = 4'd4, E_CKE = 4'd7;
`ifdef SDDR_MODEL_TIMING_CHECK_EN
  localparam logic [3:0] E_TRCD = 4'd5, E_TRP = 4'd6;
`endif

  typedef logic [PAIRS-1:0][1:0][DATA_BITS-1:0] burst_t;

  logic [NB-1:0]             open_q;
  logic [ROW_BITS-1:0]       row_q [NB];
  logic                      busy_q, fin_q, oe_q, cke_q, err_q;
  logic [3:0]                code_q;
  logic [15:0]               refcnt_q;
  logic [7:0]                cnt_q, lat_q;
  logic                      wr_q, ap_q;
  logic [BANK_BITS-1:0]      bb_q;
  logic [STORE_BITS-1:0]     slot_q;
  burst_t                    buf_q;
  logic [1:0][DATA_BITS-1:0] dq_q;
  burst_t                    mem_q [2**STORE_BITS];
`ifdef SDDR_MODEL_TIMING_CHECK_EN
  logic [7:0]                trcd_q [NB];
  logic [7:0]                trp_q [NB];
  logic [15:0]               trfc_q;
`endif

  logic [3:0]            cmd, err_code_d;
  logic                  cmd_en, ap, closing_ba, in_data;
  logic                  acc_act, acc_rw, acc_pre, acc_ref;
  logic [BANK_BITS-1:0]  ba;
  logic [COL_BITS-1:0]   col;
  logic [KEY_BITS-1:0]   key;
  logic [STORE_BITS-1:0] slot;
  logic [7:0]            beat_off;
  logic [PIDX_W-1:0]     pidx;
  logic                  unused_ok;

  assign cmd        = {ddr3_io.cs_n_i, ddr3_io.ras_n_i, ddr3_io.cas_n_i, ddr3_io.we_n_i};
  assign cmd_en     = ddr3_io.cke_i & ~ddr3_io.cs_n_i;
  assign ba         = ddr3_io.ba_i;
  assign ap         = ddr3_io.addr_i[10];
  // An auto-precharge closing this edge makes the bank unusable for the incoming command.
  assign closing_ba = fin_q & ap_q & (bb_q == ba);
  assign in_data    = busy_q && (cnt_q >= lat_q);
  assign beat_off   = cnt_q - lat_q;
  assign pidx       = beat_off[PIDX_W-1:0];
  assign key        = {ba, row_q[ba], col[COL_BITS-1:BL_LOG]};
  assign slot       = key[STORE_BITS-1:0];

  always_comb begin
    col      = '0;
    col[9:0] = ddr3_io.addr_i[9:0];
    if (COL_BITS > 10) col[COL_BITS-1] = ddr3_io.addr_i[11];
  end

  always_comb begin
    acc_act    = 1'b0;
    acc_rw     = 1'b0;
    acc_pre    = 1'b0;
    acc_ref    = 1'b0;
    err_code_d = E_NONE;
    if (cke_q && !ddr3_io.cke_i && busy_q) err_code_d = E_CKE;
    if (cmd_en) begin
      case (cmd)
        C_ACT: begin
          if (open_q[ba]) begin
`ifdef SDDR_MODEL_TIMING_CHECK_EN
            err_code_d = closing_ba ? E_TRP : E_ACT_OPEN;
`else
            err_code_d = E_ACT_OPEN;
`endif
          end
`ifdef SDDR_MODEL_TIMING_CHECK_EN
          else if (trp_q[ba] != 8'd0 || trfc_q != 16'd0) err_code_d = E_TRP;
`endif
          else acc_act = 1'b1;
        end
        C_RD, C_WR: begin
          if (!open_q[ba] || closing_ba) err_code_d = E_CLOSED;
          else if (busy_q)               err_code_d = E_BUSY;
`ifdef SDDR_MODEL_TIMING_CHECK_EN
          else if (trcd_q[ba] != 8'd0)   err_code_d = E_TRCD;
`endif
          else acc_rw = 1'b1;
        end
        C_PRE:   acc_pre = 1'b1;
        C_REF: begin
          if (|open_q) err_code_d = E_REF_OPEN;
          else         acc_ref = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control state: bank flags, burst sequencing, counters, error capture.
  always_ff @(posedge ddr_clock_i) begin
    if (ddr_reset_i) begin
      open_q   <= '0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
      oe_q     <= 1'b0;
      cke_q    <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= E_NONE;
      refcnt_q <= '0;
`ifdef SDDR_MODEL_TIMING_CHECK_EN
      for (int b = 0; b < NB; b++) begin
        trcd_q[b] <= '0;
        trp_q[b]  <= '0;
      end
      trfc_q <= '0;
`endif
    end else begin
      cke_q <= ddr3_io.cke_i;
      fin_q <= 1'b0;
      oe_q  <= in_data && !wr_q;
      if (err_code_d != E_NONE && !err_q) begin
        err_q  <= 1'b1;
        code_q <= err_code_d;
      end
`ifdef SDDR_MODEL_TIMING_CHECK_EN
      for (int b = 0; b < NB; b++) begin
        if (trcd_q[b] != 8'd0) trcd_q[b] <= trcd_q[b] - 8'd1;
        if (trp_q[b] != 8'd0)  trp_q[b]  <= trp_q[b] - 8'd1;
      end
      if (trfc_q != 16'd0) trfc_q <= trfc_q - 16'd1;
`endif
      if (busy_q && cnt_q == lat_q + P_LAST) begin
        busy_q <= 1'b0;
        fin_q  <= 1'b1;
      end
      if (fin_q && ap_q && open_q[bb_q]) begin
        open_q[bb_q] <= 1'b0;
`ifdef SDDR_MODEL_TIMING_CHECK_EN
        trp_q[bb_q] <= TRP_LD;
`endif
      end
      if (acc_pre) begin
        for (int b = 0; b < NB; b++) begin
          if ((ap || ba == BANK_BITS'(b)) && open_q[b]) begin
            open_q[b] <= 1'b0;
`ifdef SDDR_MODEL_TIMING_CHECK_EN
            trp_q[b] <= TRP_LD;
`endif
          end
        end
      end
      if (acc_act) begin
        open_q[ba] <= 1'b1;
`ifdef SDDR_MODEL_TIMING_CHECK_EN
        trcd_q[ba] <= TRCD_LD;
`endif
      end
      if (acc_ref) begin
        refcnt_q <= refcnt_q + 16'd1;
`ifdef SDDR_MODEL_TIMING_CHECK_EN
        trfc_q <= TRFC_LD;
`endif
      end
      if (acc_rw) busy_q <= 1'b1;
    end
  end

  // Data path: burst descriptor, beat buffer, backing RAM; never reset.
  always_ff @(posedge ddr_clock_i) begin
    if (busy_q) cnt_q <= cnt_q + 8'd1;
    if (in_data) begin
      if (wr_q) buf_q[pidx] <= ddr3_io.dq_i;
      else      dq_q        <= buf_q[pidx];
    end
    if (acc_act) row_q[ba] <= ddr3_io.addr_i[ROW_BITS-1:0];
    if (acc_rw) begin
      cnt_q  <= 8'd1;
      lat_q  <= (cmd == C_WR) ? WR_LAT : RD_LAT;
      wr_q   <= (cmd == C_WR);
      ap_q   <= ap;
      bb_q   <= ba;
      slot_q <= slot;
      if (cmd != C_WR) buf_q <= mem_q[slot];
    end
    if (!ddr_reset_i && fin_q && wr_q) mem_q[slot_q] <= buf_q;
  end

  assign ddr3_io.dq_o    = oe_q ? dq_q : '0;
  assign ddr3_io.dq_oe_o = oe_q;
  assign bank_open_o     = open_q;
  assign refresh_count_o = refcnt_q;
  assign err_o           = err_q;
  assign err_code_o      = code_q;

  assign unused_ok = ^{ddr3_io.odt_i, ddr3_io.addr_i, col, key, beat_off,
                       TRCD_LD, TRP_LD, TRFC_LD};
endmodule

// File: doc/sddr_device_model.md
Name: sddr_device_model

Overview:
- Synthesizable, cycle-based DDR3 device responder. It sits on the device side of the controller's phy-level pins and stands in for the memory part in simulation and loopback FPGA tests.
- Decodes CS/RAS/CAS/WE commands and tracks per-bank open rows.
- Stores write bursts in a small backing RAM and returns read bursts after CAS latency on the two-lane DQ format (lane0 = even beat, lane1 = odd beat).
- Flags protocol violations.

Parameters:
- BANK_BITS, 3, bank address width
- ROW_BITS, 13, row address width
- COL_BITS, 10, column address width
- DATA_BITS, 16, DQ width per beat
- BURST_LENGTH, 8, beats per burst (even, power of 2)
- CAS_READ_LATENCY, 5, cycles from READ to first read beat pair
- CAS_WRITE_LATENCY, 5, cycles from WRITE to first write beat pair
- STORE_BITS, 8, log2 of burst slots in backing RAM
- tRCD, 3, minimum cycles from ACTIVATE to READ/WRITE on the same bank
- tRP, 3, precharge period in cycles
- tRFC, 20, refresh period in cycles

Ports:
- ddr_clock_i  in  1  sole clock; all logic on posedge
- ddr_reset_i  in  1  synchronous reset, active-high
- ddr3_cke_i  in  1  clock enable; commands ignored when low
- ddr3_cs_n_i, ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i  in  1 each  command pins
- ddr3_ba_i  in  BANK_BITS  bank address
- ddr3_addr_i  in  ROW_BITS+$clog2(DATA_BITS/8)  row/column address; bit 10 = auto-precharge / precharge-all
- ddr3_odt_i  in  1  termination enable
- ddr3_dq_i  in  DATA_BITS x2  write data, [0] even beat, [1] odd beat
- ddr3_dq_o  out  DATA_BITS x2  read data, same lane mapping
- ddr3_dq_oe_o  out  1  read data valid/driving
- bank_open_o  out  2**BANK_BITS  per-bank row-open flags
- refresh_count_o  out  16  REFRESH commands accepted, wraps
- err_o  out  1  sticky protocol error
- err_code_o  out  4  code of first error

Behaviour:
- Reset: all outputs 0, all banks closed, counters 0, no burst pending. RAM contents are undefined and not cleared.
- Command decode: sampled only when cke=1 and cs_n=0. Encoding {cs,ras,cas,we}:
  - 0011 ACT
  - 0101 RD
  - 0100 WR
  - 0010 PRE
  - 0001 REF
  - 0000 MRS (accepted, ignored)
  - 0111 NOP
  - cs_n=1 is deselect.
- ACT: on a closed bank with its tRP counter at 0, latch row = addr[ROW_BITS-1:0], set bank_open, load the bank tRCD counter.
- RD/WR:
  - Require an open bank and no burst pending.
  - Column = {addr[11] if COL_BITS>10, addr[9:0]}; the low log2(BURST_LENGTH) column bits are ignored (aligned bursts).
  - Slot index = low STORE_BITS bits of {ba, open row, col>>log2(BURST_LENGTH)}. Aliasing is permitted.
- Read timing: RD at cycle T. dq_oe_o=1 for cycles T+CAS_READ_LATENCY through T+CAS_READ_LATENCY+BURST_LENGTH/2-1. Beat pair i is presented in the i-th of those cycles. dq_o=0 whenever oe=0.
- Write timing: WR at cycle T. ddr3_dq_i is sampled at cycles T+CAS_WRITE_LATENCY through T+CAS_WRITE_LATENCY+BURST_LENGTH/2-1. The RAM slot is written one cycle after the last pair. A RD to the same slot issued before commit returns the old data.
- Auto-precharge: addr[10]=1 on RD/WR closes the bank on the cycle after the last data pair and loads its tRP counter.
- PRE: closes ba, or all banks when addr[10]=1, and loads tRP. PRE to a closed bank is legal and does not load the counter.
- REF: requires all banks closed. Increments refresh_count_o and loads a global tRFC counter. ACT during tRFC is an error.
- Errors: the illegal command is ignored and state is unchanged. err_o sets sticky; err_code_o holds the first code only. Codes:
  - 1: ACT to open bank
  - 2: RD/WR to closed bank
  - 3: RD/WR while burst pending
  - 4: REF with any bank open
  - 5: RD/WR before tRCD expired
  - 6: ACT before tRP/tRFC expired
  - 7: burst pending when cke falls
- Simultaneous events: a new command on the cycle a burst's last pair occurs counts as "pending" and raises code 3. Auto-precharge closure and an ACT to the same bank on the same cycle raise code 6.
- Reset mid-burst: the burst is aborted, oe drops next cycle, and no RAM write is committed.

Optional Feature:
- Macro SDDR_MODEL_TIMING_CHECK_EN.
- Defined: the tRCD, tRP and tRFC counters exist and codes 5/6 are raised.
- Undefined: the counters are removed. ACT to a closed bank and RD/WR to an open bank are always legal regardless of timing. Codes 5/6 never occur. Burst latencies are unchanged.

Test Plan:
- ACT ba=2 row=0x0123; wait tRCD; WR col=0x040 with beats 0x1000..0x1007; wait; RD same -> oe high cycles T+5..T+8, lanes {0x1000,0x1001},{0x1002,0x1003},...; err_o=0.
- RD ba=1 with no ACT -> err_o=1, err_code_o=2, oe stays 0.
- ACT ba=0; RD at ACT+1 (tRCD=3) -> code 5 with the macro defined; with the macro undefined, returns data at +5 and err_o=0.
- WR with addr[10]=1 -> bank_open_o[ba] clears the cycle after the 4th pair; ACT 1 cycle later -> code 6; ACT after tRP -> accepted.
- All banks closed, REF x3 -> refresh_count_o=3; ACT at REF+5 -> code 6 (macro on); ACT after tRFC -> accepted.
- Assert reset on the 2nd read pair cycle -> oe=0 next cycle; bank_open_o=0; a later read of the interrupted WR slot returns pre-write data.
